mul_div_unit: RTL and testbench

- HI/LO multiply-divide unit for the MIPS datapath; sits directly upstream of the register file write port.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the HI/LO architectural registers.
- The writeback mux sources Write_Data from hi/lo for MFHI/MFLO.
- busy stalls the PC while an iterative divide is in flight.

---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mul_div_unit_if.sv | 28 ++
 rtl/mul_div_unit_div_iter.sv | 53 +++++
 rtl/mul_div_unit.sv | 129 ++++++++++++
 tb/tb_mul_div_unit.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit:
// op encodings, FSM states and the default datapath width.
package mdu_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        DIV_RUN,
        DIV_FIX
    } mdu_state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the decode/writeback path and the
// multiply-divide unit.
interface mul_div_unit_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mul_div_unit_div_iter.sv
// Unsigned restoring divider: one quotient bit per step, WIDTH steps.
// Sign handling lives in the parent.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             last_step
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Partial remainder stays below the divisor, so WIDTH+1 bits cover the shift.
    assign shifted   = {rem_q, quo_q[WIDTH-1]};
    assign fits      = shifted >= {1'b0, dvs_q};
    assign diff      = shifted[WIDTH-1:0] - dvs_q;
    assign last_step = (cnt_q == CW'(WIDTH - 1));
    assign quotient  = quo_q;
    assign remainder = rem_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            cnt_q <= cnt_q + 1'b1;
            rem_q <= fits ? diff : shifted[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], fits};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// HI/LO multiply-divide unit: single-cycle multiply and moves,
// iterative divide that holds busy until hi/lo are committed.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic        clk,
    input  logic        reset,
    mul_div_unit_if.slave bus
);

    mdu_state_e       state_q;
    mdu_state_e       state_d;
    mdu_op_e          op;
    logic             issue;
    logic             is_div;
    logic             rt_zero;
    logic             div_go;
    logic             sgn;
    logic             last_step;
    logic             q_neg;
    logic             r_neg;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] rs_abs;
    logic [WIDTH-1:0] rt_abs;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [2*WIDTH-1:0] sprod;
    logic [2*WIDTH-1:0] uprod;

    assign op      = mdu_op_e'(bus.op);
    assign issue   = bus.start && (state_q == IDLE);
    assign is_div  = (op == DIV) || (op == DIVU);
    assign rt_zero = (bus.rt_data == '0);
    assign div_go  = issue && is_div && !rt_zero;
    assign sgn     = (op == DIV);

    assign rs_abs = (sgn && bus.rs_data[WIDTH-1]) ? -bus.rs_data : bus.rs_data;
    assign rt_abs = (sgn && bus.rt_data[WIDTH-1]) ? -bus.rt_data : bus.rt_data;

    // Operands extended to full width so the low 2*WIDTH bits are exact.
    assign sprod = {{WIDTH{bus.rs_data[WIDTH-1]}}, bus.rs_data}
                 * {{WIDTH{bus.rt_data[WIDTH-1]}}, bus.rt_data};
    assign uprod = {{WIDTH{1'b0}}, bus.rs_data}
                 * {{WIDTH{1'b0}}, bus.rt_data};

    div_iter #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (div_go),
        .step      (state_q == DIV_RUN),
        .dividend  (rs_abs),
        .divisor   (rt_abs),
        .quotient  (quo),
        .remainder (rem),
        .last_step (last_step)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (div_go) state_d = DIV_RUN;
            DIV_RUN: if (last_step) state_d = DIV_FIX;
            DIV_FIX: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (issue) begin
                case (op)
                    MULT: begin
                        {hi_q, lo_q} <= sprod;
                        done_q       <= 1'b1;
                    end
                    MULTU: begin
                        {hi_q, lo_q} <= uprod;
                        done_q       <= 1'b1;
                    end
                    MTHI: begin
                        hi_q   <= bus.rs_data;
                        done_q <= 1'b1;
                    end
                    MTLO: begin
                        lo_q   <= bus.rs_data;
                        done_q <= 1'b1;
                    end
                    DIV, DIVU: begin
                        if (rt_zero) begin
                            hi_q   <= bus.rs_data;
                            lo_q   <= '1;
                            done_q <= 1'b1;
                        end else begin
                            q_neg <= sgn && (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
                            r_neg <= sgn && bus.rs_data[WIDTH-1];
                        end
                    end
                    default: ;
                endcase
            end else if (state_q == DIV_FIX) begin
                lo_q   <= q_neg ? -quo : quo;
                hi_q   <= r_neg ? -rem : rem;
                done_q <= 1'b1;
            end
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and random checks of mul_div_unit against an arithmetic
// reference model of HI/LO behaviour.
module tb_mul_div_unit;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   errs = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    mul_div_unit_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural values.
    task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output bit dn);
        longint sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        lat = 0;
        dn  = 1'b1;
        case (op)
            3'd0: begin sp = sa * sb; m_hi = sp[63:32]; m_lo = sp[31:0]; end
            3'd1: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; end
            3'd2, 3'd3: begin
                if (b == 0) begin
                    m_hi = a;
                    m_lo = 32'hFFFF_FFFF;
                end else if (op == 3'd2) begin
                    sp = sa / sb; m_lo = sp[31:0];
                    sp = sa % sb; m_hi = sp[31:0];
                    lat = 33;
                end else begin
                    up = ua / ub; m_lo = up[31:0];
                    up = ua % ub; m_hi = up[31:0];
                    lat = 33;
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: dn = 1'b0;
        endcase
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs_data = a;
        bus.rt_data = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit chk_fall);
        int lat;
        bit dn;
        int cyc;
        ref_op(op, a, b, lat, dn);
        issue(op, a, b);
        if (lat == 0) begin
            check({tag, " busy"}, bus.busy, 0);
        end else begin
            cyc = 0;
            while (bus.busy && cyc < 100) begin
                cyc++;
                @(posedge clk);
                #1;
            end
            check({tag, " busy cycles"}, cyc, lat);
        end
        check({tag, " done"}, bus.done, dn);
        check({tag, " hi"}, bus.hi, m_hi);
        check({tag, " lo"}, bus.lo, m_lo);
        if (chk_fall) begin
            @(posedge clk);
            #1;
            check({tag, " done fall"}, bus.done, 0);
        end
    endtask

    initial begin
        int lat;
        bit dn;
        int cyc;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.op      = '0;
        bus.rs_data = '0;
        bus.rt_data = '0;
        #12;
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset hi", bus.hi, 0);
        check("reset lo", bus.lo, 0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mult neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 1'b1);
        check("mult hi const", bus.hi, 32'hFFFF_FFFF);
        check("mult lo const", bus.lo, 32'hFFFF_FFF1);
        run_op("multu max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        check("multu hi const", bus.hi, 32'hFFFF_FFFE);
        run_op("mthi", 3'd4, 32'h1234_5678, 32'd0, 1'b0);
        check("mthi lo kept", bus.lo, 32'h0000_0001);
        run_op("mtlo in done", 3'd5, 32'hCAFE_F00D, 32'd0, 1'b1);
        run_op("div -7/2", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
        check("div lo const", bus.lo, 32'hFFFF_FFFD);
        run_op("divu 100/7", 3'd3, 32'd100, 32'd7, 1'b1);
        check("divu lo const", bus.lo, 32'h0000_000E);
        run_op("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check("div ovf lo const", bus.lo, 32'h8000_0000);
        run_op("divu by0", 3'd3, 32'h55, 32'd0, 1'b1);
        run_op("unused op", 3'd6, 32'h1111_1111, 32'h2222_2222, 1'b1);

        // start during a divide must not disturb it
        ref_op(3'd3, 32'd1000, 32'd3, lat, dn);
        issue(3'd3, 32'd1000, 32'd3);
        cyc = 0;
        while (bus.busy && cyc < 100) begin
            cyc++;
            if (cyc == 5) begin
                @(negedge clk);
                bus.start   = 1'b1;
                bus.op      = 3'd0;
                bus.rs_data = 32'd7;
                bus.rt_data = 32'd9;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        check("ign busy cycles", cyc, lat);
        check("ign lo", bus.lo, 32'h0000_014D);
        check("ign hi", bus.hi, 32'h0000_0001);
        check("ign done", bus.done, 1);

        // asynchronous reset mid-divide
        issue(3'd2, 32'd12345, 32'hFFFF_FFEF);
        cyc = 1;
        while (cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        #2;
        reset = 1'b0;
        #1;
        check("rst busy", bus.busy, 0);
        check("rst done", bus.done, 0);
        check("rst hi", bus.hi, 0);
        check("rst lo", bus.lo, 0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        run_op("mult 6*7", 3'd0, 32'd6, 32'd7, 1'b1);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 5) == 0) rb = '0;
            else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
            if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
            run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, i[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
